// File: rtl/ex_mult_if.sv
// Request/result bundle between the EX-stage control and the multiplier.
interface ex_mult_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, signed_op, flush, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, signed_op, flush, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/ex_mult_ctrl.sv
// Sequential shift-and-add MULT/MULTU unit: one add per cycle, HI/LO result.
module ex_mult_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
    ex_mult_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplr;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic [WIDTH-1:0] a_abs_c;
    logic [WIDTH-1:0] b_abs_c;
    logic [WIDTH:0]   sum_c;
    logic [PW-1:0]    prod_c;
    logic [PW-1:0]    res_c;

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;

    // Operand magnitudes; 0x80..0 maps to itself and is then read as unsigned.
    assign a_abs_c = (bus.signed_op && bus.op_a[WIDTH-1]) ? (~bus.op_a + WIDTH'(1)) : bus.op_a;
    assign b_abs_c = (bus.signed_op && bus.op_b[WIDTH-1]) ? (~bus.op_b + WIDTH'(1)) : bus.op_b;

    // One iteration: carry-keeping add, then the whole {acc, mplr} shifts right.
    assign sum_c  = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : (WIDTH+1)'(0));
    assign prod_c = {acc, mplr};
    assign res_c  = neg ? (~prod_c + PW'(1)) : prod_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    // Registered handshake outputs, decoded from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == CALC) || (state_nxt == FIX);
            done <= (state_nxt == DONE);
        end
    end

    // Datapath: operand load, iteration, and HI/LO write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            mplr  <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        mcand <= a_abs_c;
                        mplr  <= b_abs_c;
                        neg   <= bus.signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    acc  <= sum_c[WIDTH:1];
                    mplr <= {sum_c[0], mplr[WIDTH-1:1]};
                    cnt  <= cnt + CW'(1);
                end
                FIX: begin
                    if (!bus.flush) begin
                        hi <= res_c[PW-1:WIDTH];
                        lo <= res_c[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
